mem_stage_access_ctrl: RTL and testbench

//  Sequences data-memory transactions for the instruction held in the EX/MEM pipeline register.

---
 rtl/mem_stage_access_ctrl_pkg.sv | 33 +++
 rtl/mem_stage_access_ctrl_if.sv | 20 ++
 rtl/mem_stage_access_ctrl_load_align.sv | 43 ++++
 rtl/mem_stage_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_access_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: RV32I load/store FUNCT3
// codes, controller state encoding and the access legality rule.
package mem_stage_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Exactly one of read/write, a known size, natural alignment; stores have no unsigned forms.
  function automatic logic op_legal(input logic i_rd, input logic i_wr,
                                    input logic [2:0] i_f3, input logic [1:0] i_lo);
    logic ok;
    case (i_f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~i_lo[0];
      F3_LW:         ok = (i_lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok & (i_rd ^ i_wr) & ~(i_wr & i_f3[2]);
  endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the memory.
interface mem_stage_access_ctrl_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/mem_stage_access_ctrl_load_align.sv
// Byte-lane decode for an access: byte enables from size/offset, and lane select
// plus sign/zero extension of the returned read word.
module mem_load_align
  import mem_stage_access_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  // Size field alone decides the lane mask, so loads and stores share it.
  always_comb begin
    o_byte_en = 4'b0000;
    case (i_funct3[1:0])
      2'b00:   o_byte_en = 4'b0001 << i_addr_lo;
      2'b01:   o_byte_en = 4'b0011 << {i_addr_lo[1], 1'b0};
      2'b10:   o_byte_en = 4'b1111;
      default: o_byte_en = 4'b0000;
    endcase
  end

  // Extract and extend the addressed lane.
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_load_data = i_rdata;
      F3_LBU:  o_load_data = {24'h00_0000, w_byte};
      F3_LHU:  o_load_data = {16'h0000, w_half};
      default: o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access sequencer: turns the EX/MEM load/store into a req/ack
// transaction, stalls the pipeline until it completes and returns extended load data.
module mem_stage_access_ctrl
  import mem_stage_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [2:0]              FUNCT3,
  input  logic [31:0]             ADDRESS,
  input  logic [31:0]             STORE_DATA,
  mem_stage_access_ctrl_if.master bus,
  output logic [31:0]             LOAD_DATA,
  output logic                    STALL,
  output logic                    ACCESS_FAULT,
  output logic                    MEM_ERROR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_load_data;
  logic             r_error;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_is_load;

  logic             w_op;
  logic             w_legal;
  logic             w_ack;
  logic             w_timeout;
  logic [2:0]       w_funct3;
  logic [1:0]       w_addr_lo;
  logic [3:0]       w_be;
  logic [31:0]      w_load_data;
  logic [31:0]      w_wdata;

  assign w_op      = MEM_READ | MEM_WRITE;
  assign w_legal   = op_legal(MEM_READ, MEM_WRITE, FUNCT3, ADDRESS[1:0]);
  assign w_ack     = (r_state == ST_REQ) && bus.MEM_ACK;
  assign w_timeout = (r_state == ST_REQ) && !bus.MEM_ACK && (r_cnt == CNT_LAST);

  // The decoder sees the live op while issuing and the latched op while waiting for ACK.
  assign w_funct3  = (r_state == ST_REQ) ? r_funct3  : FUNCT3;
  assign w_addr_lo = (r_state == ST_REQ) ? r_addr_lo : ADDRESS[1:0];

  mem_load_align u_align (
    .i_funct3    (w_funct3),
    .i_addr_lo   (w_addr_lo),
    .i_rdata     (bus.MEM_RDATA),
    .o_byte_en   (w_be),
    .o_load_data (w_load_data)
  );

  always_comb begin
    w_wdata = STORE_DATA;
    case (FUNCT3[1:0])
      2'b00:   w_wdata = {4{STORE_DATA[7:0]}};
      2'b01:   w_wdata = {2{STORE_DATA[15:0]}};
      default: w_wdata = STORE_DATA;
    endcase
  end

  // Next state plus the combinational stall/fault; both are forced low while in reset.
  always_comb begin
    w_next_state = r_state;
    STALL        = 1'b0;
    ACCESS_FAULT = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_legal) begin
          w_next_state = ST_REQ;
          STALL        = 1'b1;
        end else begin
          ACCESS_FAULT = w_op;
        end
      end
      ST_REQ: begin
        STALL = 1'b1;
        if (w_ack || w_timeout) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (RESET) begin
      STALL        = 1'b0;
      ACCESS_FAULT = 1'b0;
    end else begin
      STALL        = STALL;
      ACCESS_FAULT = ACCESS_FAULT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bus outputs stay frozen from issue until ACK; only MEM_REQ drops when the access ends.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_be        <= 4'b0000;
      r_load_data <= 32'h0000_0000;
      r_error     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_is_load   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            r_req     <= 1'b1;
            r_we      <= MEM_WRITE;
            r_addr    <= {ADDRESS[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_be      <= w_be;
            r_funct3  <= FUNCT3;
            r_addr_lo <= ADDRESS[1:0];
            r_is_load <= MEM_READ;
            r_cnt     <= '0;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            r_req <= 1'b0;
            if (r_is_load) begin
              r_load_data <= w_load_data;
            end
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_error <= 1'b1;
            if (r_is_load) begin
              r_load_data <= 32'h0000_0000;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.MEM_REQ     = r_req;
  assign bus.MEM_WE      = r_we;
  assign bus.MEM_ADDR    = r_addr;
  assign bus.MEM_WDATA   = r_wdata;
  assign bus.MEM_BYTE_EN = r_be;
  assign LOAD_DATA       = r_load_data;
  assign MEM_ERROR       = r_error;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Randomized scoreboard bench for mem_stage_access_ctrl with a behavioural memory responder.
module tb_mem_stage_access_ctrl;

  localparam int T = 4;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    int stall;
    int fault;
  } opx_t;

  typedef struct {
    int          dly;
    logic [31:0] rdata;
  } rsp_t;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] STORE_DATA;
  logic [31:0] LOAD_DATA;
  logic        STALL;
  logic        ACCESS_FAULT;
  logic        MEM_ERROR;

  mem_stage_access_ctrl_if u_if ();

  mem_stage_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .FUNCT3       (FUNCT3),
    .ADDRESS      (ADDRESS),
    .STORE_DATA   (STORE_DATA),
    .bus          (u_if),
    .LOAD_DATA    (LOAD_DATA),
    .STALL        (STALL),
    .ACCESS_FAULT (ACCESS_FAULT),
    .MEM_ERROR    (MEM_ERROR)
  );

  bus_t bus_q[$];
  opx_t op_q[$];
  rsp_t rsp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (access rules as arithmetic) ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    longint span;
    int sz;
    sz   = size_of(f3);
    span = 64'd1 << (8 * sz);
    v    = longint'(rd >> (8 * (a % 4))) & (span - 1);
    if (sz < 4 && !f3[2] && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // ---------------- stimulus ----------------
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int dly, input logic [31:0] rdata);
    bit   lg;
    bit   done;
    opx_t x;
    bus_t b;
    rsp_t r;
    @(negedge CLK);
    MEM_READ   = rd;
    MEM_WRITE  = wr;
    FUNCT3     = f3;
    ADDRESS    = a;
    STORE_DATA = d;
    if (!rd && !wr) return;
    lg      = ref_legal(rd, wr, f3, a);
    x.stall = lg ? 1 + ((dly < T) ? dly : T) : 0;
    x.fault = lg ? 0 : 1;
    op_q.push_back(x);
    if (lg) begin
      b.we = wr; b.f3 = f3; b.addr = a; b.data = d;
      bus_q.push_back(b);
      r.dly = dly; r.rdata = rdata;
      rsp_q.push_back(r);
    end
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!STALL) done = 1'b1;
      else @(negedge CLK);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL op_release: STALL still high after 40 cycles, expected release");
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    bit   busy;
    int   cnt;
    rsp_t r;
    busy = 1'b0;
    cnt  = 0;
    r.dly = 1000; r.rdata = 32'h0;
    forever begin
      @(negedge CLK);
      u_if.MEM_ACK = 1'b0;
      if (u_if.MEM_REQ) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (rsp_q.size() > 0) r = rsp_q.pop_front();
          else begin r.dly = 1000; r.rdata = 32'h0; end
        end
        cnt++;
        if (cnt == r.dly) begin
          u_if.MEM_ACK   = 1'b1;
          u_if.MEM_RDATA = r.rdata;
        end
      end else begin
        busy = 1'b0;
        // Stray acknowledges while no request is open must be ignored.
        if ($urandom_range(0, 7) == 0) begin
          u_if.MEM_ACK   = 1'b1;
          u_if.MEM_RDATA = $urandom;
        end
      end
    end
  end

  // ---------------- monitor: pipeline-side stall/fault per op ----------------
  initial begin : mon_pipe
    int   sc;
    int   fc;
    opx_t e;
    sc = 0;
    fc = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET) begin
        op_q.delete();
        sc = 0;
        fc = 0;
        chk("stall_in_reset", 32'(STALL), 32'd0);
        chk("fault_in_reset", 32'(ACCESS_FAULT), 32'd0);
      end else begin
        sc += int'(STALL);
        fc += int'(ACCESS_FAULT);
        if ((MEM_READ || MEM_WRITE) && !STALL) begin
          if (op_q.size() == 0) begin
            chk("op_expected", 32'd0, 32'd1);
          end else begin
            e = op_q.pop_front();
            chk("stall_cycles", 32'(sc), 32'(e.stall));
            chk("fault_pulses", 32'(fc), 32'(e.fault));
          end
          sc = 0;
          fc = 0;
        end else if (!(MEM_READ || MEM_WRITE)) begin
          chk("bubble_stall", 32'(STALL), 32'd0);
          chk("bubble_fault", 32'(ACCESS_FAULT), 32'd0);
        end
      end
    end
  end

  // ---------------- monitor: memory bus and load result ----------------
  initial begin : mon_bus
    bus_t        cur;
    int          rc;
    bit          active;
    logic [31:0] m_load;
    bit          m_err;
    active = 1'b0;
    rc     = 0;
    m_load = 32'h0;
    m_err  = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET) begin
        active = 1'b0;
        m_load = 32'h0;
        m_err  = 1'b0;
        bus_q.delete();
        chk("rst_req", 32'(u_if.MEM_REQ), 32'd0);
        chk("rst_we", 32'(u_if.MEM_WE), 32'd0);
        chk("rst_addr", u_if.MEM_ADDR, 32'd0);
        chk("rst_wdata", u_if.MEM_WDATA, 32'd0);
        chk("rst_be", 32'(u_if.MEM_BYTE_EN), 32'd0);
      end else if (active) begin
        rc++;
        if (u_if.MEM_ACK) begin
          if (!cur.we) m_load = ref_load(cur.f3, cur.addr, u_if.MEM_RDATA);
          chk("req_drop_ack", 32'(u_if.MEM_REQ), 32'd0);
          active = 1'b0;
        end else if (rc == T) begin
          m_err = 1'b1;
          if (!cur.we) m_load = 32'h0;
          chk("req_drop_timeout", 32'(u_if.MEM_REQ), 32'd0);
          active = 1'b0;
        end else begin
          chk("req_held", 32'(u_if.MEM_REQ), 32'd1);
          chk("addr_held", u_if.MEM_ADDR, cur.addr & 32'hFFFF_FFFC);
          chk("be_held", 32'(u_if.MEM_BYTE_EN), 32'(ref_be(cur.f3, cur.addr)));
        end
      end else if (u_if.MEM_REQ) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur    = bus_q.pop_front();
          active = 1'b1;
          rc     = 0;
          chk("req_we", 32'(u_if.MEM_WE), 32'(cur.we));
          chk("req_addr", u_if.MEM_ADDR, cur.addr & 32'hFFFF_FFFC);
          chk("req_be", 32'(u_if.MEM_BYTE_EN), 32'(ref_be(cur.f3, cur.addr)));
          if (cur.we) chk("req_wdata", u_if.MEM_WDATA, ref_wdata(cur.f3, cur.data));
        end
      end
      chk("load_data", LOAD_DATA, m_load);
      chk("mem_error", 32'(MEM_ERROR), 32'(m_err));
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit          rd;
    bit          wr;
    int          k;
    logic [2:0]  f3;
    logic [31:0] a;
    RESET          = 1'b1;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    FUNCT3         = 3'b000;
    ADDRESS        = 32'h0;
    STORE_DATA     = 32'h0;
    u_if.MEM_ACK   = 1'b0;
    u_if.MEM_RDATA = 32'h0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hCAFE_F00D);   // LW, ACK on 3rd REQ cycle
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 1, 32'h0);   // SB lane 3
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 2, 32'h0080_FF00);   // LB
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 1, 32'h0080_FF00);   // LBU
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0);           // LH misaligned
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 1, 32'h0);           // read+write together
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 100, 32'h0);         // no ACK -> timeout
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 4, 32'h8001_7FFF);   // LHU, ACK on last cycle

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      rd = 1'b0;
      wr = 1'b0;
      if (k == 1) begin rd = 1'b1; wr = 1'b1; end
      else if (k >= 2 && k < 6) rd = 1'b1;
      else if (k >= 6) wr = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(rd, wr, f3, a, $urandom, $urandom_range(1, 6), $urandom);
    end

    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 100, 32'h0);         // make MEM_ERROR sticky
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 2, 32'h1234_5678);

    // RESET in the middle of an open request.
    @(negedge CLK);
    MEM_READ  = 1'b1;
    MEM_WRITE = 1'b0;
    FUNCT3    = 3'b010;
    ADDRESS   = 32'h0000_0400;
    begin
      bus_t b;
      rsp_t r;
      b.we = 1'b0; b.f3 = 3'b010; b.addr = 32'h0000_0400; b.data = 32'h0;
      bus_q.push_back(b);
      r.dly = 100; r.rdata = 32'h0;
      rsp_q.push_back(r);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET    = 1'b1;
    MEM_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0501, 32'h0, 1, 32'h0000_9C00);   // LB after reset
    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    repeat (3) @(negedge CLK);

    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("op_q_drained", 32'(op_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
